// File: rtl/const_block_arbiter_pkg.sv
// Shared types and helpers for the constant-block arbiter.
// The build macro CONST_ARB_MSB_FIRST_EN (see const_block_arbiter) selects the address direction.
package const_arb_pkg;

  localparam int REGISTER_SIZE_DEFAULT = 32;
  localparam int NUM_BLOCKS_DEFAULT    = 128;
  localparam int BLOCK_IDX_W           = $clog2(NUM_BLOCKS_DEFAULT);
  localparam int MAX_REQ               = 8;

  typedef logic [REGISTER_SIZE_DEFAULT-1:0] block_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Circular search: first set request at or after ptr, wrapping at n.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input logic [3:0]         n);
    logic       found;
    logic [3:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && req[idx[2:0]]) begin
        rr_pick = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/const_block_arbiter_skid_fifo.sv
// Two-entry skid FIFO holding store read data plus its last-block tag.
// The head entry is the registered output; the second entry absorbs one in-flight read.
module block_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        count,
  output logic              valid
);

  logic [DATA_W-1:0] skid_data;
  logic              skid_last;
  logic              take;

  always_comb begin
    valid = (count != 2'd0);
    take  = pop & valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      rd_data <= '0;
      rd_last <= 1'b0;
    end else begin
      case ({push, take})
        2'b10: begin
          if (count == 2'd0) begin
            rd_data <= wr_data;
            rd_last <= wr_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            rd_data <= skid_data;
            rd_last <= skid_last;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            rd_data <= wr_data;
            rd_last <= wr_last;
          end else begin
            rd_data <= skid_data;
            rd_last <= skid_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Second entry carries data only; occupancy alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (push && (((count == 2'd1) && !take) || ((count == 2'd2) && take))) begin
      skid_data <= wr_data;
      skid_last <= wr_last;
    end
  end

endmodule

// File: rtl/const_block_arbiter.sv
// Round-robin arbiter sharing one single-port constant store between NUM_REQ block streams.
// Define CONST_ARB_MSB_FIRST_EN to issue addresses NUM_BLOCKS-1 down to 0.
module const_block_arbiter
  import const_arb_pkg::*;
#(
  parameter int REGISTER_SIZE = REGISTER_SIZE_DEFAULT,
  parameter int NUM_BLOCKS    = NUM_BLOCKS_DEFAULT,
  parameter int NUM_REQ       = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic                          rom_rd_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] rom_addr_out,
  input  logic [REGISTER_SIZE-1:0]      rom_data_in,
  output logic [REGISTER_SIZE-1:0]      data_out,
  output logic [NUM_REQ-1:0]            valid_out,
  input  logic [NUM_REQ-1:0]            ready_in,
  output logic                          last_out,
  output logic                          busy_out
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int CNT_W = IDX_W + 1;
  localparam int REQ_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

`ifdef CONST_ARB_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] ADDR_START = LAST_IDX;
`else
  localparam logic [IDX_W-1:0] ADDR_START = '0;
`endif

  state_t             state;
  logic [REQ_W-1:0]   gidx;
  logic [REQ_W-1:0]   rr_ptr;
  logic [REQ_W-1:0]   pick;
  logic [2:0]         pick_full;
  logic [CNT_W-1:0]   rd_cnt;
  logic [IDX_W-1:0]   addr;
  logic               vld_p1;
  logic               last_p1;

  logic [1:0]         fifo_cnt;
  logic               fifo_valid;
  logic               fifo_last;
  logic               owner_ready;
  logic               pop;
  logic               rd;
  logic               last_hs;
  logic [2:0]         credit;
  logic [2:0]         limit;

  always_comb begin
    pick_full   = rr_pick(MAX_REQ'(req_in), 3'(rr_ptr), 4'(NUM_REQ));
    pick        = pick_full[REQ_W-1:0];
    owner_ready = |(grant_out & ready_in);
    pop         = fifo_valid & owner_ready;
    last_hs     = pop & fifo_last;
    // A block leaving this cycle frees a slot for a read issued this cycle.
    credit      = {1'b0, fifo_cnt} + {2'b00, vld_p1};
    limit       = 3'd2 + {2'b00, pop};
    rd          = (state == STREAM) && (rd_cnt < CNT_W'(NUM_BLOCKS)) && (credit < limit);
    rom_rd_out   = rd;
    rom_addr_out = addr;
    valid_out    = grant_out & {NUM_REQ{fifo_valid}};
    last_out     = fifo_last & fifo_valid;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      grant_out <= '0;
      busy_out  <= 1'b0;
      gidx      <= '0;
      rr_ptr    <= '0;
      rd_cnt    <= '0;
      addr      <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      // p0 -> p1: store read issued, data returns next cycle
      vld_p1  <= rd;
      last_p1 <= rd && (rd_cnt == CNT_W'(NUM_BLOCKS - 1));
      case (state)
        IDLE: begin
          if (|req_in) begin
            gidx      <= pick;
            grant_out <= NUM_REQ'(1) << pick;
            busy_out  <= 1'b1;
            rd_cnt    <= '0;
            addr      <= ADDR_START;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (rd) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt != CNT_W'(NUM_BLOCKS - 1)) begin
`ifdef CONST_ARB_MSB_FIRST_EN
              addr <= addr - IDX_W'(1);
`else
              addr <= addr + IDX_W'(1);
`endif
            end
          end
          if (last_hs) begin
            grant_out <= '0;
            busy_out  <= 1'b0;
            rr_ptr    <= (gidx == REQ_W'(NUM_REQ - 1)) ? '0 : gidx + REQ_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p1 -> p2: returned data captured into the skid FIFO head
  block_skid_fifo #(
    .DATA_W (REGISTER_SIZE)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .push    (vld_p1),
    .pop     (pop),
    .wr_data (rom_data_in),
    .wr_last (last_p1),
    .rd_data (data_out),
    .rd_last (fifo_last),
    .count   (fifo_cnt),
    .valid   (fifo_valid)
  );

endmodule

// File: tb/tb_const_block_arbiter.sv
// Scoreboard bench for const_block_arbiter: expected bursts are queued at request time and
// compared by a negedge monitor against every store read and every block handshake.
`timescale 1ns/1ps
module tb_const_block_arbiter;

  localparam int RS = 32;
  localparam int NB = 128;
  localparam int NR = 2;
  localparam int AW = $clog2(NB);

  logic          clk = 1'b0;
  logic          rst_in;
  logic [NR-1:0] req_in;
  logic [NR-1:0] grant_out;
  logic          rom_rd_out;
  logic [AW-1:0] rom_addr_out;
  logic [RS-1:0] rom_data_in;
  logic [RS-1:0] data_out;
  logic [NR-1:0] valid_out;
  logic [NR-1:0] ready_in;
  logic          last_out;
  logic          busy_out;

  always #5 clk = ~clk;

  const_block_arbiter #(
    .REGISTER_SIZE (RS),
    .NUM_BLOCKS    (NB),
    .NUM_REQ       (NR)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .req_in       (req_in),
    .grant_out    (grant_out),
    .rom_rd_out   (rom_rd_out),
    .rom_addr_out (rom_addr_out),
    .rom_data_in  (rom_data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .last_out     (last_out),
    .busy_out     (busy_out)
  );

  typedef struct {
    int            req;
    logic [RS-1:0] data;
    bit            last;
  } blk_t;

  blk_t exp_q[$];
  int   addr_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   out_cnt = 0;
  int   hs_in_burst = 0;
  int   rd_total = 0;
  int   cyc = 0;
  int   first_hs_cyc = 0;
  int   last_hs_cyc = 0;
  int   rr_model = 0;
  bit   idle_chk = 0;

  function automatic logic [RS-1:0] rom_val(input int a);
    return RS'(3 * a + 1);
  endfunction

  function automatic int addr_of(input int k);
`ifdef CONST_ARB_MSB_FIRST_EN
    return NB - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic int rr_pick_model(input int ptr, input logic [NR-1:0] req);
    for (int i = 0; i < NR; i++)
      if (req[(ptr + i) % NR]) return (ptr + i) % NR;
    return 0;
  endfunction

  // Constant store: one-cycle read latency, garbage when not read.
  always @(posedge clk)
    rom_data_in <= rom_rd_out ? rom_val(int'(rom_addr_out)) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_in) begin
      logic hs;
      blk_t e;
      hs = |(valid_out & ready_in);
      if (idle_chk) begin
        chk("idle_gap_grant", grant_out, '0);
        chk("idle_gap_busy", busy_out, 1'b0);
        idle_chk = 0;
      end
      if (rom_rd_out) begin
        rd_total++;
        if (addr_q.size() == 0)
          note_fail($sformatf("rd_unexpected: actual read at addr %0d, required no read", rom_addr_out));
        else
          chk("rom_addr", rom_addr_out, addr_q.pop_front());
      end
      if (valid_out != '0) chk("valid_owner", valid_out & ~grant_out, '0);
      if (hs) begin
        if (exp_q.size() == 0)
          note_fail($sformatf("hs_unexpected: actual data %0h, required no block", data_out));
        else begin
          e = exp_q.pop_front();
          chk("grant_idx", grant_out, NR'(1) << e.req);
          chk("data", data_out, e.data);
          chk("last", last_out, e.last);
        end
        if (hs_in_burst == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_in_burst++;
        if (last_out) idle_chk = 1;
      end
      out_cnt = out_cnt + int'(rom_rd_out) - int'(hs);
      if (rom_rd_out) chk("outstanding_le2", out_cnt <= 2, 1'b1);
    end
  end

  task automatic push_burst(input int g);
    for (int k = 0; k < NB; k++) begin
      blk_t e;
      e.req  = g;
      e.data = rom_val(addr_of(k));
      e.last = (k == NB - 1);
      exp_q.push_back(e);
      addr_q.push_back(addr_of(k));
    end
    hs_in_burst = 0;
    rr_model = (g + 1) % NR;
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    req_in   = '0;
    ready_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.delete();
    addr_q.delete();
    out_cnt  = 0;
    idle_chk = 0;
    rr_model = 0;
    rst_in   = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (grant_out != '0) ok = 1;
    end
    if (!ok) note_fail("grant_timeout: actual grant_out 0, required a grant");
    @(posedge clk); #1;
  endtask

  task automatic wait_release();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (grant_out == '0) ok = 1;
    end
    if (!ok) note_fail("release_timeout: actual grant held, required release");
  endtask

  // mode 0: ready high, 1: alternate 1/0, 2: random
  task automatic run_burst(input int mode);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      case (mode)
        0:       ready_in = '1;
        1:       ready_in = (i % 2 == 0) ? '1 : '0;
        default: ready_in = NR'($urandom);
      endcase
      @(negedge clk);
      if (exp_q.size() == 0 && grant_out == '0) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      note_fail($sformatf("burst_timeout: actual %0d blocks pending, required 0", exp_q.size()));
      do_reset();
    end
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    bit            ok;
    int            g;
    int            rd0;
    logic [NR-1:0] mask;

    rst_in = 1'b1; req_in = '0; ready_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant_out, '0);
    chk("rst_rd", rom_rd_out, 1'b0);
    chk("rst_addr", rom_addr_out, '0);
    chk("rst_data", data_out, '0);
    chk("rst_valid", valid_out, '0);
    chk("rst_last", last_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    @(posedge clk); #1;
    rst_in = 1'b0;

    // Single requester, ready always high: latency and throughput
    ready_in = '1;
    req_in   = 2'b01;
    rd0      = rd_total;
    g = rr_pick_model(rr_model, req_in);
    push_burst(g);
    @(negedge clk);
    chk("p1_grant_same_cycle", grant_out, '0);
    @(negedge clk);
    chk("p1_grant_next", grant_out, 2'b01);
    chk("p1_busy", busy_out, 1'b1);
    chk("p1_first_rd", rom_rd_out, 1'b1);
    chk("p1_first_addr", rom_addr_out, addr_of(0));
    @(negedge clk);
    chk("p1_valid_t2", valid_out, '0);
    @(negedge clk);
    chk("p1_valid_t3", valid_out, 2'b01);
    chk("p1_first_data", data_out, rom_val(addr_of(0)));
    @(posedge clk); #1;
    req_in = '0;
    run_burst(0);
    chk("p1_reads", rd_total - rd0, NB);
    chk("p1_hs_span", last_hs_cyc - first_hs_cyc, NB - 1);

    // Both requesters from reset: strict alternation
    do_reset();
    ready_in = '1;
    req_in   = 2'b11;
    for (int b = 0; b < 3; b++) begin
      g = rr_pick_model(rr_model, req_in);
      push_burst(g);
      wait_grant(ok);
      chk("p2_grant_order", grant_out, NR'(1) << g);
      if (b == 2) req_in = '0;
      wait_release();
    end
    chk("p2_all_delivered", exp_q.size(), 0);

    // Alternating backpressure
    rd0    = rd_total;
    req_in = 2'b01;
    g = rr_pick_model(rr_model, req_in);
    push_burst(g);
    wait_grant(ok);
    req_in = '0;
    run_burst(1);
    chk("p3_reads", rd_total - rd0, NB);

    // Stall right after grant
    ready_in = '0;
    req_in   = 2'b01;
    rd0      = rd_total;
    g = rr_pick_model(rr_model, req_in);
    push_burst(g);
    wait_grant(ok);
    req_in = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_out != '0) chk("p4_stall_data", data_out, rom_val(addr_of(0)));
    end
    chk("p4_stall_reads", rd_total - rd0, 2);
    chk("p4_stall_valid", valid_out, NR'(1) << g);
    @(posedge clk); #1;
    run_burst(0);

    // Reset around the 50th handshake of a requester-1 burst
    req_in = 2'b10;
    g = rr_pick_model(rr_model, req_in);
    push_burst(g);
    wait_grant(ok);
    chk("p5_grant_before", grant_out, 2'b10);
    req_in   = '0;
    ready_in = '1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (hs_in_burst >= 50) ok = 1;
    end
    if (!ok) note_fail($sformatf("p5_hs_timeout: actual %0d handshakes, required 50", hs_in_burst));
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("p5_rst_grant", grant_out, '0);
    chk("p5_rst_rd", rom_rd_out, 1'b0);
    chk("p5_rst_addr", rom_addr_out, '0);
    chk("p5_rst_data", data_out, '0);
    chk("p5_rst_valid", valid_out, '0);
    chk("p5_rst_last", last_out, 1'b0);
    chk("p5_rst_busy", busy_out, 1'b0);
    exp_q.delete();
    addr_q.delete();
    out_cnt  = 0;
    idle_chk = 0;
    rr_model = 0;
    @(posedge clk); #1;
    rst_in = 1'b0;
    req_in = 2'b11;
    g = rr_pick_model(rr_model, req_in);
    push_burst(g);
    wait_grant(ok);
    chk("p5_restart_grant", grant_out, 2'b01);
    req_in = '0;
    run_burst(0);

    // Random request masks with random consumer readiness
    for (int n = 0; n < 6; n++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      req_in = mask;
      g = rr_pick_model(rr_model, mask);
      push_burst(g);
      wait_grant(ok);
      chk("rand_grant", grant_out, NR'(1) << g);
      req_in = '0;
      run_burst(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
